// File: rtl/spi_fsm_pkg.sv
// Shared definitions for the SPI memory controller FSM.
// Contents:
//   state_t           - 3-bit state encoding (IDLE=0 ... DONE=7), visible on state_dbg
//   DEFAULT_WORD_BITS - default bits per address / data byte
//   RW_READ/RW_WRITE  - meaning of the R/W bit that follows the address byte
package spi_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        GET_ADDR     = 3'd1,
        DECODE       = 3'd2,
        READ_LOAD    = 3'd3,
        READ_SHIFT   = 3'd4,
        WRITE_RECV   = 3'd5,
        WRITE_COMMIT = 3'd6,
        DONE         = 3'd7
    } state_t;

    localparam int DEFAULT_WORD_BITS = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for one SPI byte field.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset (count -> 0)
//   inc   - count one relevant sclk edge this cycle
//   clr   - force count to 0 (idle / abort)
//   term  - terminal value, WORD_BITS-1
//   done  - high in the cycle where inc lands on the terminal value
// The count returns to 0 on the terminal increment, so it never exceeds term.
module spi_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_comb begin
        done = inc && (count == term);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_fsm_controller.sv
// SPI memory datapath sequencer.
// Consumes the conditioned chip select and one-clk sclk edge pulses and
// drives the datapath write enables as a Moore decode of the state register.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   cs_n                - conditioned chip select, active low
//   sclk_pos / sclk_neg - one-clk pulses on sclk rising / falling edges
//   rw_bit              - R/W bit after the address byte (1 = read)
//   addr_we             - address latch write enable (DECODE)
//   sr_we               - shift-register parallel load (READ_LOAD)
//   dm_we               - data memory write enable (WRITE_COMMIT)
//   miso_buff           - MISO tri-state enable (READ_SHIFT)
//   state_dbg           - current state encoding
module spi_fsm_controller
    import spi_fsm_pkg::*;
#(
    parameter int WORD_BITS = DEFAULT_WORD_BITS,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       sclk_pos,
    input  logic       sclk_neg,
    input  logic       rw_bit,
    output logic       addr_we,
    output logic       sr_we,
    output logic       dm_we,
    output logic       miso_buff,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(WORD_BITS - 1);

    state_t state, next_state;
    logic   cnt_inc, cnt_clr, cnt_done;

    spi_bit_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .term  (TERM),
        .done  (cnt_done)
    );

    // Only the edge that matters in the current state is counted, and never
    // while cs_n is high: abort wins over any same-cycle pulse.
    always_comb begin
        cnt_inc = 1'b0;
        case (state)
            GET_ADDR, WRITE_RECV: cnt_inc = sclk_pos;
            READ_SHIFT:           cnt_inc = sclk_neg;
            default:              cnt_inc = 1'b0;
        endcase
        cnt_inc = cnt_inc && !cs_n;
        cnt_clr = cs_n || (state == IDLE);
    end

    always_comb begin
        next_state = state;
        if (cs_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:         next_state = GET_ADDR;
                GET_ADDR:     if (cnt_done) next_state = DECODE;
                DECODE:       next_state = (rw_bit == RW_READ) ? READ_LOAD : WRITE_RECV;
                READ_LOAD:    next_state = READ_SHIFT;
                READ_SHIFT:   if (cnt_done) next_state = DONE;
                WRITE_RECV:   if (cnt_done) next_state = WRITE_COMMIT;
                WRITE_COMMIT: next_state = DONE;
                DONE:         next_state = DONE;
                default:      next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign addr_we   = (state == DECODE);
    assign sr_we     = (state == READ_LOAD);
    assign dm_we     = (state == WRITE_COMMIT);
    assign miso_buff = (state == READ_SHIFT);
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_fsm_controller.sv
// Bench for spi_fsm_controller. The driver applies one cycle of inputs,
// advances a transaction-level reference model and pushes the expected
// {state, addr_we, sr_we, dm_we, miso_buff} after that edge into exp_q.
// The monitor pops one entry per clock and compares it with the DUT.
module tb_spi_fsm_controller;
    import spi_fsm_pkg::*;

    localparam int W = 7;
    localparam int WB = DEFAULT_WORD_BITS;

    logic clk = 1'b0;
    logic reset, cs_n, sclk_pos, sclk_neg, rw_bit;
    logic addr_we, sr_we, dm_we, miso_buff;
    logic [2:0] state_dbg;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;
    logic cur_rw = 1'b0;

    spi_fsm_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .rw_bit    (rw_bit),
        .addr_we   (addr_we),
        .sr_we     (sr_we),
        .dm_we     (dm_we),
        .miso_buff (miso_buff),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks where the transaction is and how many bits of the current
    // field have arrived; strobes follow from the phase.
    state_t m_phase = IDLE;
    int     m_bits  = 0;

    task automatic model_step(input logic r, input logic cs, input logic pos,
                              input logic neg, input logic rw);
        if (r) begin
            m_phase = IDLE; m_bits = 0;
        end else if (cs) begin
            m_phase = IDLE; m_bits = 0;
        end else begin
            case (m_phase)
                IDLE: m_phase = GET_ADDR;
                GET_ADDR, WRITE_RECV, READ_SHIFT: begin
                    if ((m_phase == READ_SHIFT) ? neg : pos) m_bits++;
                    if (m_bits == WB) begin
                        m_bits = 0;
                        if (m_phase == GET_ADDR)        m_phase = DECODE;
                        else if (m_phase == WRITE_RECV) m_phase = WRITE_COMMIT;
                        else                            m_phase = DONE;
                    end
                end
                DECODE:       m_phase = rw ? READ_LOAD : WRITE_RECV;
                READ_LOAD:    m_phase = READ_SHIFT;
                WRITE_COMMIT: m_phase = DONE;
                default:      m_phase = DONE;
            endcase
        end
    endtask

    function automatic logic [W-1:0] expected_outputs(input state_t p);
        return {3'(p), p == DECODE, p == READ_LOAD, p == WRITE_COMMIT, p == READ_SHIFT};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input logic r, input logic cs, input logic pos, input logic neg);
        reset = r; cs_n = cs; sclk_pos = pos; sclk_neg = neg; rw_bit = cur_rw;
        model_step(r, cs, pos, neg, cur_rw);
        exp_q.push_back(expected_outputs(m_phase));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic cs);
        for (int i = 0; i < n; i++) tick(1'b0, cs, 1'b0, 1'b0);
    endtask

    // n relevant pulses (pos or neg) with random gaps; the other edge is
    // sprinkled in as noise that must be ignored.
    task automatic pulses(input int n, input logic use_pos);
        for (int i = 0; i < n; i++) begin
            logic noise;
            noise = 1'($urandom_range(0, 1));
            if (use_pos) tick(1'b0, 1'b0, 1'b1, noise);
            else         tick(1'b0, 1'b0, noise, 1'b1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                noise = 1'($urandom_range(0, 1));
                if (use_pos) tick(1'b0, 1'b0, 1'b0, noise);
                else         tick(1'b0, 1'b0, noise, 1'b0);
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v, got_v;
            exp_v = exp_q.pop_front();
            got_v = {state_dbg, addr_we, sr_we, dm_we, miso_buff};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs cycle=%0d got state=%0d aw=%b sw=%b dw=%b mb=%b want state=%0d aw=%b sw=%b dw=%b mb=%b",
                         cycle, got_v[6:4], got_v[3], got_v[2], got_v[1], got_v[0],
                         exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
        cycle++;
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset state
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // read transaction
        cur_rw = 1'b1;
        idle(1, 1'b0);
        pulses(WB, 1'b1);
        idle(2, 1'b0);
        pulses(WB, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // write transaction, then DONE hold with 10 pulse pairs
        cur_rw = 1'b0;
        idle(1, 1'b0);
        pulses(WB, 1'b1);
        idle(1, 1'b0);
        pulses(WB, 1'b1);
        idle(2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            tick(1'b0, 1'b0, 1'b1, 1'b1);
        end
        idle(1, 1'b1);

        // abort after 3 address bits, then a full read
        idle(1, 1'b0);
        pulses(3, 1'b1);
        idle(2, 1'b1);
        cur_rw = 1'b1;
        idle(1, 1'b0);
        pulses(WB, 1'b1);
        idle(2, 1'b0);
        pulses(WB, 1'b0);
        idle(2, 1'b1);

        // reset mid-read after 4 sclk_neg, cs_n held low throughout
        idle(1, 1'b0);
        pulses(WB, 1'b1);
        idle(2, 1'b0);
        pulses(4, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        pulses(WB - 1, 1'b1);
        idle(2, 1'b0);
        pulses(1, 1'b1);
        idle(2, 1'b0);
        idle(1, 1'b1);

        // abort coinciding with the 8th address bit; sclk_neg-only in GET_ADDR
        idle(1, 1'b0);
        pulses(WB - 1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // random soak
        for (int i = 0; i < 600; i++) begin
            cur_rw = 1'($urandom_range(0, 1));
            tick(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end
        idle(2, 1'b1);

        // drain the scoreboard
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
